// File: rtl/spi_receiver_pkg.sv
// ----------------------------------------------------------------------------
// spi_receiver_pkg
//   Shared configuration for the multi-lane SPI receive path: default lane
//   count, frame length, stall timeout, the receiver FSM state type and a
//   helper that sizes the beat counter.
// ----------------------------------------------------------------------------
package spi_receiver_pkg;

  localparam int P_DATA_WIDTH        = 8;
  localparam int P_FRAME_BEATS       = 2;
  localparam int P_RX_TIMEOUT_CYCLES = 1000;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  // Width of a counter that must hold 0 .. n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_receiver_if.sv
// ----------------------------------------------------------------------------
// spi_receiver_if
//   Output side of the SPI receiver: assembled words on a valid/ready
//   handshake plus the two single-cycle status pulses.
//   master : drives valid, data, overflow, frame_err; samples ready
//   slave  : samples valid, data, overflow, frame_err; drives ready
// ----------------------------------------------------------------------------
interface spi_receiver_if #(
  parameter int WIDTH = 16
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             overflow;
  logic             frame_err;

  modport master (
    output valid,
    output data,
    output overflow,
    output frame_err,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  overflow,
    input  frame_err,
    output ready
  );

endinterface

// File: rtl/spi_rx_sync.sv
// ----------------------------------------------------------------------------
// spi_rx_sync
//   Two-flop synchronizer for a group of asynchronous inputs. Every bit of
//   the group sees the same depth, so lanes launched together stay together.
//   clk       : destination clock
//   rst_n     : asynchronous reset, active-low; both stages load RESET_VAL
//   d         : asynchronous input group
//   q         : synchronized output group
// ----------------------------------------------------------------------------
module spi_rx_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments let both stages sample the value from
  // before the edge; blocking ones would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_receiver.sv
// ----------------------------------------------------------------------------
// spi_receiver
//   Receiving end of the multi-lane SPI link (mode 0: SCK idles low, CS
//   active-low, MOSI sampled on SCK rise, first beat = MSBs). SCK/CS/MOSI are
//   synchronized into clk_100, FRAME_BEATS beats are packed into one word and
//   the word is offered on a valid/ready interface.
//   Optional feature macro: SPI_RX_TIMEOUT_EN -- aborts a partial frame when
//   SCK stalls for TIMEOUT_CYCLES clk_100 cycles while CS is low.
//
//   clk_100 : system clock, the only clock
//   a_rst   : asynchronous reset, active-low
//   SCK     : serial clock from the transmitter (asynchronous, <= 25 MHz)
//   CS      : chip select, active-low (asynchronous)
//   MOSI    : DATA_WIDTH parallel lanes (asynchronous)
//   out_if  : valid/ready/data toward downstream + overflow/frame_err pulses
// ----------------------------------------------------------------------------
module spi_receiver
  import spi_receiver_pkg::*;
#(
  parameter int DATA_WIDTH     = P_DATA_WIDTH,
  parameter int FRAME_BEATS    = P_FRAME_BEATS,
  parameter int TIMEOUT_CYCLES = P_RX_TIMEOUT_CYCLES
) (
  input  logic                  clk_100,
  input  logic                  a_rst,
  input  logic                  SCK,
  input  logic                  CS,
  input  logic [DATA_WIDTH-1:0] MOSI,
  spi_receiver_if.master        out_if
);

  localparam int                 WORD_W    = DATA_WIDTH * FRAME_BEATS;
  localparam int                 CNT_W     = cnt_width(FRAME_BEATS);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

  // --------------------------------------------------------------------------
  // Input synchronization (equal depth for all groups keeps MOSI aligned to
  // the SCK edge that qualifies it)
  // --------------------------------------------------------------------------
  logic                  sck_s2;
  logic                  sck_s3;
  logic                  cs_s;
  logic [DATA_WIDTH-1:0] mosi_s;
  logic                  sck_rise;

  spi_rx_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_sck (
    .clk (clk_100), .rst_n (a_rst), .d (SCK), .q (sck_s2)
  );

  spi_rx_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_cs (
    .clk (clk_100), .rst_n (a_rst), .d (CS), .q (cs_s)
  );

  spi_rx_sync #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_sync_mosi (
    .clk (clk_100), .rst_n (a_rst), .d (MOSI), .q (mosi_s)
  );

  always_ff @(posedge clk_100 or negedge a_rst) begin
    if (!a_rst) sck_s3 <= 1'b0;
    else        sck_s3 <= sck_s2;
  end

  assign sck_rise = sck_s2 & ~sck_s3;

  // --------------------------------------------------------------------------
  // Frame FSM: shift register, beat counter, optional stall timeout
  // --------------------------------------------------------------------------
  rx_state_t         state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic              complete;     // assembled word ready, consumed next cycle
  logic              frame_err_q;

`ifdef SPI_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_100 or negedge a_rst) begin
    if (!a_rst) begin
      state       <= RX_IDLE;
      beat_cnt    <= '0;
      shift_reg   <= '0;
      complete    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      complete    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        RX_IDLE: begin
          // SCK activity while deselected is ignored here.
          if (!cs_s) begin
            state <= RX_SHIFT;
`ifdef SPI_RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        RX_SHIFT: begin
          if (cs_s) begin
            state    <= RX_IDLE;
            beat_cnt <= '0;
            if (beat_cnt != '0) frame_err_q <= 1'b1;
          end else if (sck_rise) begin
            // Shift left so the first beat ends up in the MSBs.
            shift_reg <= (shift_reg << DATA_WIDTH) | WORD_W'(mosi_s);
`ifdef SPI_RX_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;      // stay in SHIFT: back-to-back frames allowed
              complete <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
`ifdef SPI_RX_TIMEOUT_EN
          end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            // Stall reached TIMEOUT_CYCLES since the last SCK rise.
            idle_cnt <= '0;
            if (beat_cnt != '0) begin
              beat_cnt    <= '0;
              frame_err_q <= 1'b1;
            end
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
`endif
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Holding register and valid/ready handshake
  // --------------------------------------------------------------------------
  logic              valid_q;
  logic [WORD_W-1:0] data_q;
  logic              overflow_q;

  always_ff @(posedge clk_100 or negedge a_rst) begin
    if (!a_rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (complete) begin
        // A transfer on this same edge frees the slot for the new word.
        if (!valid_q || out_if.ready) begin
          data_q  <= shift_reg;
          valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (valid_q && out_if.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.valid     = valid_q;
  assign out_if.data      = data_q;
  assign out_if.overflow  = overflow_q;
  assign out_if.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_receiver.sv
// ----------------------------------------------------------------------------
// tb_spi_receiver
//   Self-checking bench for spi_receiver (DATA_WIDTH=8, FRAME_BEATS=2).
//   Stimulus pushes expected words into a queue; a monitor on the falling
//   edge pops and compares on every valid & ready, and counts status pulses.
// ----------------------------------------------------------------------------
module tb_spi_receiver;

  localparam int DW  = 8;
  localparam int FB  = 2;
  localparam int WW  = DW * FB;
  localparam int TMO = 1000;

  logic          clk = 1'b0;
  logic          a_rst;
  logic          SCK;
  logic          CS;
  logic [DW-1:0] MOSI;

  spi_receiver_if #(.WIDTH(WW)) bus ();

  spi_receiver #(
    .DATA_WIDTH     (DW),
    .FRAME_BEATS    (FB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_100 (clk),
    .a_rst   (a_rst),
    .SCK     (SCK),
    .CS      (CS),
    .MOSI    (MOSI),
    .out_if  (bus)
  );

  always #5 clk = ~clk;

  int            n_vec      = 0;
  int            n_miss     = 0;
  logic [WW-1:0] exp_q[$];
  int            ovf_pulses = 0;
  int            ovf_high   = 0;
  int            err_pulses = 0;
  int            err_high   = 0;
  logic          ovf_d      = 1'b0;
  logic          err_d      = 1'b0;
  logic          prev_hold  = 1'b0;
  logic [WW-1:0] prev_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] b, input int half);
    MOSI = b;
    SCK  = 1'b0;
    repeat (half) tick();
    SCK  = 1'b1;
    repeat (half) tick();
  endtask

  // Reference model: the word is the beats read as base-2^DW digits, first beat most significant.
  task automatic send_frame(input logic [WW-1:0] w, input int half);
    logic [DW-1:0] beats[FB];
    logic [WW-1:0] model;
    logic [WW-1:0] rest;
    rest = w;
    for (int i = FB - 1; i >= 0; i--) begin
      beats[i] = rest[DW-1:0];
      rest     = rest >> DW;
    end
    model = '0;
    for (int i = 0; i < FB; i++) model = model * (1 << DW) + WW'(beats[i]);
    exp_q.push_back(model);
    for (int i = 0; i < FB; i++) send_beat(beats[i], half);
    SCK = 1'b0;
    repeat (half) tick();
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!a_rst) begin
      ovf_d     = 1'b0;
      err_d     = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (bus.overflow) begin
        ovf_high++;
        if (!ovf_d) ovf_pulses++;
      end
      if (bus.frame_err) begin
        err_high++;
        if (!err_d) err_pulses++;
      end
      ovf_d = bus.overflow;
      err_d = bus.frame_err;
      if (prev_hold && bus.valid) check("hold_stable", 32'(bus.data), 32'(prev_data));
      if (bus.valid && bus.ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_word: got %0h expected none", bus.data);
        end else begin
          check("word", 32'(bus.data), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = bus.valid & ~bus.ready;
      prev_data = bus.data;
    end
  end

  initial begin
    logic [WW-1:0] wa;
    logic [WW-1:0] wb;
    int            e0;
    int            o0;
    int            n;

    a_rst     = 1'b0;
    SCK       = 1'b0;
    CS        = 1'b1;
    MOSI      = '0;
    bus.ready = 1'b1;
    repeat (3) tick();
    check("rst_valid",     32'(bus.valid),     0);
    check("rst_data",      32'(bus.data),      0);
    check("rst_overflow",  32'(bus.overflow),  0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    a_rst = 1'b1;
    repeat (3) tick();

    // Basic frame with latency and single-cycle valid under ready=1.
    CS = 1'b0;
    repeat (4) tick();
    exp_q.push_back(16'hA53C);
    send_beat(8'hA5, 4);
    MOSI = 8'h3C;
    SCK  = 1'b0;
    repeat (4) tick();
    SCK = 1'b1;
    repeat (3) tick();
    check("lat_not_yet", 32'(bus.valid), 0);
    tick();
    check("lat_valid", 32'(bus.valid), 1);
    check("lat_data",  32'(bus.data),  32'h0000A53C);
    tick();
    check("valid_one_cycle", 32'(bus.valid), 0);
    repeat (3) tick();
    SCK = 1'b0;
    repeat (4) tick();
    CS = 1'b1;
    repeat (6) tick();
    check("basic_no_ovf", 32'(ovf_pulses), 0);
    check("basic_no_err", 32'(err_pulses), 0);

    // Overflow: two frames while downstream stalls.
    bus.ready = 1'b0;
    CS = 1'b0;
    repeat (4) tick();
    send_frame(16'h1234, 4);
    exp_q.pop_back();               // re-queued below so only one entry exists
    exp_q.push_back(16'h1234);
    send_frame(16'h5678, 4);
    exp_q.pop_back();               // this word is dropped by the receiver
    repeat (6) tick();
    check("ovf_once",   32'(ovf_pulses), 1);
    check("ovf_valid",  32'(bus.valid),  1);
    check("ovf_data",   32'(bus.data),   32'h00001234);
    CS = 1'b1;
    repeat (4) tick();
    bus.ready = 1'b1;
    tick();
    check("ovf_drained", 32'(bus.valid), 0);

    // Completion on the same edge as a transfer.
    bus.ready = 1'b0;
    o0 = ovf_pulses;
    wa = WW'($urandom);
    wb = ~wa;
    CS = 1'b0;
    repeat (4) tick();
    send_frame(wa, 3);
    repeat (6) tick();
    exp_q.push_back(wb);
    send_beat(wb[WW-1:DW], 3);
    MOSI = wb[DW-1:0];
    SCK  = 1'b0;
    repeat (3) tick();
    SCK = 1'b1;
    repeat (3) tick();
    bus.ready = 1'b1;
    tick();
    check("same_cycle_valid", 32'(bus.valid), 1);
    check("same_cycle_data",  32'(bus.data),  32'(wb));
    tick();
    check("same_cycle_done",  32'(bus.valid), 0);
    check("same_cycle_no_ovf", 32'(ovf_pulses), 32'(o0));
    SCK = 1'b0;
    repeat (3) tick();
    CS = 1'b1;
    repeat (5) tick();

    // Partial frame aborted by CS, then a clean frame.
    e0 = err_pulses;
    CS = 1'b0;
    repeat (4) tick();
    send_beat(8'hFF, 4);
    SCK = 1'b0;
    repeat (4) tick();
    CS = 1'b1;
    repeat (6) tick();
    check("cs_abort_err",   32'(err_pulses), 32'(e0 + 1));
    check("cs_abort_valid", 32'(bus.valid),  0);
    CS = 1'b0;
    repeat (4) tick();
    send_frame(16'hBEEF, 4);
    repeat (4) tick();
    CS = 1'b1;
    repeat (6) tick();
    check("beef_consumed", 32'(exp_q.size()), 0);

    // Reset mid-frame, then a clean frame.
    e0 = err_pulses;
    CS = 1'b0;
    repeat (4) tick();
    send_beat(8'h12, 4);
    SCK   = 1'b0;
    a_rst = 1'b0;
    tick();
    check("midrst_valid", 32'(bus.valid), 0);
    check("midrst_data",  32'(bus.data),  0);
    tick();
    a_rst = 1'b1;
    CS    = 1'b1;
    repeat (6) tick();
    CS = 1'b0;
    repeat (4) tick();
    send_frame(16'hC0DE, 4);
    repeat (4) tick();
    CS = 1'b1;
    repeat (6) tick();
    check("midrst_no_err", 32'(err_pulses), 32'(e0));
    check("c0de_consumed", 32'(exp_q.size()), 0);

    // Randomized bursts: 1-3 back-to-back frames per CS, random SCK rate.
    for (int burst = 0; burst < 8; burst++) begin
      int half;
      half = int'($urandom_range(2, 5));
      CS = 1'b0;
      repeat (int'($urandom_range(3, 6))) tick();
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) send_frame(WW'($urandom), half);
      repeat (4) tick();
      CS = 1'b1;
      repeat (int'($urandom_range(4, 8))) tick();
    end

    // Stalled SCK with one beat received.
    e0 = err_pulses;
    CS = 1'b0;
    repeat (4) tick();
    MOSI = 8'h5A;
    SCK  = 1'b0;
    repeat (4) tick();
    SCK = 1'b1;
`ifdef SPI_RX_TIMEOUT_EN
    n = 0;
    while (err_pulses == e0 && n < 3000) begin
      tick();
      n++;
    end
    check("timeout_err",     32'(err_pulses), 32'(e0 + 1));
    check("timeout_latency", 32'((n >= TMO) && (n <= TMO + 8)), 1);
    SCK = 1'b0;
    tick();
    CS = 1'b1;
    repeat (6) tick();
    check("timeout_no_extra", 32'(err_pulses), 32'(e0 + 1));
`else
    n = 0;
    repeat (2000) tick();
    check("no_timeout", 32'(err_pulses), 32'(e0));
    SCK = 1'b0;
    tick();
    CS = 1'b1;
    repeat (6) tick();
    check("stall_cs_err", 32'(err_pulses), 32'(e0 + 1));
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("queue_drained",  32'(exp_q.size()), 0);
    check("ovf_total",      32'(ovf_pulses),   1);
    check("ovf_width",      32'(ovf_high),     32'(ovf_pulses));
    check("err_width",      32'(err_high),     32'(err_pulses));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
